// File: rtl/jesd204_dac_tx_source.sv
// Sample source for a JESD204 DAC link. It streams pass-through DAC data, a
// ramp, a constant or zeros into tx_tdata, aligned to the first multiframe after enable.
module jesd204_dac_tx_source #(
    parameter logic [15:0] RAMP_SEED = 16'h0000,
    parameter int          UFLOW_W   = 16
) (
    input  logic               tx_core_clk,
    input  logic               tx_aresetn,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [15:0]        const_val,
    input  logic               uflow_clr,
    input  logic [255:0]       dac_data,
    input  logic               dac_valid,
    output logic               dac_ready,
    input  logic               tx_tready,
    input  logic [3:0]         tx_start_of_multiframe,
    output logic [255:0]       tx_tdata,
    output logic               running,
    output logic [UFLOW_W-1:0] uflow_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_MF = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    state_t             state_q, state_d;
    logic [255:0]       tdata_q, tdata_d;
    logic [15:0]        ramp_base_q, ramp_base_d;
    logic [UFLOW_W-1:0] uflow_q, uflow_d;
    logic               running_q;
    logic               link_ok;
    logic               run_update;

    // Only the lane-0 multiframe marker is used for alignment.
    logic unused_somf;
    assign unused_somf = ^tx_start_of_multiframe[3:1];

    assign link_ok    = enable & tx_tready;
    assign run_update = (state_q == RUN) & link_ok;

    assign dac_ready = tx_tready & (state_q == RUN) & (mode == MODE_PASS);
    assign tx_tdata  = tdata_q;
    assign running   = running_q;
    assign uflow_cnt = uflow_q;

    always_comb begin
        state_d     = state_q;
        tdata_d     = tdata_q;
        ramp_base_d = ramp_base_q;
        uflow_d     = uflow_q;

        case (state_q)
            IDLE: begin
                tdata_d = '0;
                if (link_ok) state_d = WAIT_MF;
            end
            WAIT_MF: begin
                tdata_d = '0;
                if (!link_ok)                       state_d = IDLE;
                else if (tx_start_of_multiframe[0]) state_d = RUN;
            end
            RUN: begin
                // Leaving RUN freezes the word; IDLE flushes it to zeros next cycle.
                if (!link_ok) begin
                    state_d = IDLE;
                end else begin
                    case (mode)
                        MODE_PASS:  tdata_d = dac_valid ? dac_data : '0;
                        MODE_RAMP: begin
                            for (int c = 0; c < 4; c++) begin
                                for (int s = 0; s < 4; s++) begin
                                    tdata_d[64*c + 16*s +: 16] = ramp_base_q + 16'(s);
                                end
                            end
                        end
                        MODE_CONST: tdata_d = {16{const_val}};
                        default:    tdata_d = '0;
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
                tdata_d = '0;
            end
        endcase

        // The ramp phase only survives while continuously streaming ramp words.
        if ((state_q != RUN) || (mode != MODE_RAMP)) begin
            ramp_base_d = RAMP_SEED;
        end else if (run_update) begin
            ramp_base_d = ramp_base_q + 16'd4;
        end

        if (uflow_clr) begin
            uflow_d = '0;
        end else if (run_update && (mode == MODE_PASS) && !dac_valid && !(&uflow_q)) begin
            uflow_d = uflow_q + UFLOW_W'(1);
        end
    end

    always_ff @(posedge tx_core_clk or negedge tx_aresetn) begin
        if (!tx_aresetn) begin
            state_q     <= IDLE;
            tdata_q     <= '0;
            ramp_base_q <= RAMP_SEED;
            uflow_q     <= '0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tdata_q     <= tdata_d;
            ramp_base_q <= ramp_base_d;
            uflow_q     <= uflow_d;
            running_q   <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_jesd204_dac_tx_source.sv
// Directed bench for jesd204_dac_tx_source: a vector table for single-cycle
// behaviour plus hand sequences for startup, ramp wrap, pass-through, underflow and reset.
module tb_jesd204_dac_tx_source;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [1:0]   mode;
    logic [15:0]  const_val;
    logic         uflow_clr;
    logic [255:0] dac_data;
    logic         dac_valid;
    logic         tx_tready;
    logic [3:0]   somf;

    logic         dac_ready, dac_ready2;
    logic [255:0] tx_tdata, tx_tdata2;
    logic         running, running2;
    logic [15:0]  uflow_cnt;
    logic [2:0]   uflow_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jesd204_dac_tx_source dut (
        .tx_core_clk(clk), .tx_aresetn(rst_n), .enable(enable), .mode(mode),
        .const_val(const_val), .uflow_clr(uflow_clr), .dac_data(dac_data),
        .dac_valid(dac_valid), .dac_ready(dac_ready), .tx_tready(tx_tready),
        .tx_start_of_multiframe(somf), .tx_tdata(tx_tdata), .running(running),
        .uflow_cnt(uflow_cnt)
    );

    // Second instance exercises ramp wrap-around and counter saturation.
    jesd204_dac_tx_source #(.RAMP_SEED(16'hFFF8), .UFLOW_W(3)) dut2 (
        .tx_core_clk(clk), .tx_aresetn(rst_n), .enable(enable), .mode(mode),
        .const_val(const_val), .uflow_clr(uflow_clr), .dac_data(dac_data),
        .dac_valid(dac_valid), .dac_ready(dac_ready2), .tx_tready(tx_tready),
        .tx_start_of_multiframe(somf), .tx_tdata(tx_tdata2), .running(running2),
        .uflow_cnt(uflow_cnt2)
    );

    typedef struct {
        string       name;
        logic        en, rdy;
        logic [1:0]  md;
        logic        mf, valid;
        logic [7:0]  dseed;
        logic [15:0] cval;
        logic        clr;
        logic        expReady;
        int          expKind;
        logic [15:0] expVal;
        logic        expRun;
        logic [15:0] expUflow;
    } vec_t;

    localparam int K_ZERO  = 0;
    localparam int K_RAMP  = 1;
    localparam int K_CONST = 2;
    localparam int K_DAC   = 3;
    localparam int K_SKIP  = 4;

    vec_t vecs[$];

    function automatic logic [255:0] dacWord(input logic [7:0] seed);
        logic [255:0] w;
        for (int k = 0; k < 16; k++) w[16*k +: 16] = {seed, 8'(k)};
        return w;
    endfunction

    function automatic logic [255:0] rampWord(input logic [15:0] base);
        logic [255:0] w;
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 4; s++)
                w[64*c + 16*s +: 16] = 16'(base + 16'(s));
        return w;
    endfunction

    function automatic logic [255:0] constWord(input logic [15:0] v);
        logic [255:0] w;
        for (int k = 0; k < 16; k++) w[16*k +: 16] = v;
        return w;
    endfunction

    function automatic logic [255:0] expWord(input int kind, input logic [15:0] v);
        case (kind)
            K_RAMP:  return rampWord(v);
            K_CONST: return constWord(v);
            K_DAC:   return dacWord(v[7:0]);
            default: return '0;
        endcase
    endfunction

    function automatic vec_t mk(input string nm, input logic en, input logic rdy,
                                input logic [1:0] md, input logic mf, input logic valid,
                                input logic [7:0] dseed, input logic [15:0] cval,
                                input logic clr, input logic eReady, input int eKind,
                                input logic [15:0] eVal, input logic eRun,
                                input logic [15:0] eUflow);
        vec_t v;
        v.name = nm; v.en = en; v.rdy = rdy; v.md = md; v.mf = mf; v.valid = valid;
        v.dseed = dseed; v.cval = cval; v.clr = clr; v.expReady = eReady;
        v.expKind = eKind; v.expVal = eVal; v.expRun = eRun; v.expUflow = eUflow;
        return v;
    endfunction

    task automatic checkOutput(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rdy, input logic [1:0] md,
                         input logic mf, input logic valid, input logic [255:0] data,
                         input logic [15:0] cval, input logic clr);
        enable = en; tx_tready = rdy; mode = md; somf = {3'b000, mf};
        dac_valid = valid; dac_data = data; const_val = cval; uflow_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.en, v.rdy, v.md, v.mf, v.valid, dacWord(v.dseed), v.cval, v.clr);
        #1;
        checkOutput({v.name, "_ready"}, 256'(dac_ready), 256'(v.expReady));
        tick();
        if (v.expKind != K_SKIP)
            checkOutput({v.name, "_tdata"}, tx_tdata, expWord(v.expKind, v.expVal));
        checkOutput({v.name, "_running"}, 256'(running), 256'(v.expRun));
        checkOutput({v.name, "_uflow"}, 256'(uflow_cnt), 256'(v.expUflow));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        //            name                 en rdy md mf vl seed cval     clr rdy kind     val      run uf
        vecs.push_back(mk("idle_to_wait",     1, 1, 1, 0, 0, 0, 16'h0,    0, 0, K_ZERO,  16'h0,    0, 0));
        vecs.push_back(mk("wait_hold",        1, 1, 1, 0, 0, 0, 16'h0,    0, 0, K_ZERO,  16'h0,    0, 0));
        vecs.push_back(mk("somf_enter",       1, 1, 1, 1, 0, 0, 16'h0,    0, 0, K_ZERO,  16'h0,    1, 0));
        vecs.push_back(mk("ramp_w0",          1, 1, 1, 0, 0, 0, 16'h0,    0, 0, K_RAMP,  16'h0,    1, 0));
        vecs.push_back(mk("ramp_w1",          1, 1, 1, 0, 0, 0, 16'h0,    0, 0, K_RAMP,  16'h4,    1, 0));
        vecs.push_back(mk("const_1234",       1, 1, 2, 0, 0, 0, 16'h1234, 0, 0, K_CONST, 16'h1234, 1, 0));
        vecs.push_back(mk("ramp_restart",     1, 1, 1, 0, 0, 0, 16'h0,    0, 0, K_RAMP,  16'h0,    1, 0));
        vecs.push_back(mk("pass_a",           1, 1, 0, 0, 1, 1, 16'h0,    0, 1, K_DAC,   16'h1,    1, 0));
        vecs.push_back(mk("pass_b",           1, 1, 0, 0, 1, 2, 16'h0,    0, 1, K_DAC,   16'h2,    1, 0));
        vecs.push_back(mk("uflow_1",          1, 1, 0, 0, 0, 3, 16'h0,    0, 1, K_ZERO,  16'h0,    1, 1));
        vecs.push_back(mk("uflow_2",          1, 1, 0, 0, 0, 4, 16'h0,    0, 1, K_ZERO,  16'h0,    1, 2));
        vecs.push_back(mk("uflow_clr_wins",   1, 1, 0, 0, 0, 5, 16'h0,    1, 1, K_ZERO,  16'h0,    1, 0));
        vecs.push_back(mk("zero_mode",        1, 1, 3, 0, 1, 6, 16'h0,    0, 0, K_ZERO,  16'h0,    1, 0));
        vecs.push_back(mk("const_00ab",       1, 1, 2, 0, 1, 7, 16'h00AB, 0, 0, K_CONST, 16'h00AB, 1, 0));
        vecs.push_back(mk("tready_drop_hold", 1, 0, 2, 0, 1, 7, 16'h00AB, 0, 0, K_CONST, 16'h00AB, 0, 0));
        vecs.push_back(mk("idle_ignores_mf",  1, 1, 1, 1, 0, 0, 16'h0,    0, 0, K_ZERO,  16'h0,    0, 0));
        vecs.push_back(mk("wait_no_mf",       1, 1, 1, 0, 0, 0, 16'h0,    0, 0, K_ZERO,  16'h0,    0, 0));
        vecs.push_back(mk("wait_enable_drop", 0, 1, 1, 1, 0, 0, 16'h0,    0, 0, K_ZERO,  16'h0,    0, 0));
        vecs.push_back(mk("idle_to_wait2",    1, 1, 1, 0, 0, 0, 16'h0,    0, 0, K_ZERO,  16'h0,    0, 0));
        vecs.push_back(mk("somf_enter2",      1, 1, 1, 1, 0, 0, 16'h0,    0, 0, K_ZERO,  16'h0,    1, 0));
        vecs.push_back(mk("ramp_reseeded",    1, 1, 1, 0, 0, 0, 16'h0,    0, 0, K_RAMP,  16'h0,    1, 0));
        vecs.push_back(mk("enable_drop_run",  0, 1, 1, 0, 0, 0, 16'h0,    0, 0, K_SKIP,  16'h0,    0, 0));
        vecs.push_back(mk("idle_zero",        0, 1, 1, 0, 0, 0, 16'h0,    0, 0, K_ZERO,  16'h0,    0, 0));

        // Reset values, with inputs that would otherwise raise dac_ready.
        rst_n = 1'b0;
        drive(1, 1, 0, 0, 1, dacWord(8'h55), 16'h0, 0);
        repeat (3) tick();
        checkOutput("reset_tdata", tx_tdata, '0);
        checkOutput("reset_running", 256'(running), 256'(0));
        checkOutput("reset_uflow", 256'(uflow_cnt), 256'(0));
        checkOutput("reset_ready", 256'(dac_ready), 256'(0));
        enable = 1'b0;
        rst_n  = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Pass-through with incrementing data: every word appears one cycle later.
        drive(1, 1, 0, 0, 0, '0, 16'h0, 0); tick();
        drive(1, 1, 0, 1, 0, '0, 16'h0, 0); tick();
        checkOutput("pass_enter_running", 256'(running), 256'(1));
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 0, 1, dacWord(8'(100 + i)), 16'h0, 0);
            #1;
            checkOutput($sformatf("pass_ready_%0d", i), 256'(dac_ready), 256'(1));
            tick();
            checkOutput($sformatf("pass_data_%0d", i), tx_tdata, dacWord(8'(100 + i)));
        end

        // Underflow: five starved cycles, then more to saturate the narrow counter.
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 0, 0, 0, dacWord(8'hEE), 16'h0, 0);
            tick();
            checkOutput($sformatf("uflow_zero_%0d", i), tx_tdata, '0);
            if (i == 4) checkOutput("uflow_five", 256'(uflow_cnt), 256'(5));
        end
        checkOutput("uflow_nine", 256'(uflow_cnt), 256'(9));
        checkOutput("uflow_saturate", 256'(uflow_cnt2), 256'(7));
        drive(1, 1, 0, 0, 0, '0, 16'h0, 1); tick();
        checkOutput("uflow_clr_pulse", 256'(uflow_cnt), 256'(0));
        checkOutput("uflow_clr_pulse2", 256'(uflow_cnt2), 256'(0));

        // Startup timing: marker in cycle 10 after reset, ramp on both seeds.
        rst_n = 1'b0;
        drive(1, 1, 1, 0, 0, '0, 16'h0, 0);
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            checkOutput($sformatf("start_idle_run_%0d", cyc), 256'(running), 256'(0));
            checkOutput($sformatf("start_idle_data_%0d", cyc), tx_tdata, '0);
            somf = {3'b000, (cyc == 10)};
            tick();
        end
        somf = 4'b0000;
        checkOutput("start_running_c11", 256'(running), 256'(1));
        checkOutput("start_running2_c11", 256'(running2), 256'(1));
        checkOutput("start_data_c11", tx_tdata, '0);
        tick();
        checkOutput("start_ramp_w0", tx_tdata, rampWord(16'h0000));
        checkOutput("wrap_ramp_w0", tx_tdata2, rampWord(16'hFFF8));
        tick();
        checkOutput("start_ramp_w1", tx_tdata, rampWord(16'h0004));
        checkOutput("wrap_ramp_w1", tx_tdata2, rampWord(16'hFFFC));
        tick();
        checkOutput("start_ramp_w2", tx_tdata, rampWord(16'h0008));
        checkOutput("wrap_ramp_w2", tx_tdata2, rampWord(16'h0000));

        // Asynchronous reset between edges, then constant mode after re-entry.
        #2;
        mode  = 2'd0;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_tdata", tx_tdata, '0);
        checkOutput("async_rst_running", 256'(running), 256'(0));
        checkOutput("async_rst_ready", 256'(dac_ready), 256'(0));
        tick();
        rst_n = 1'b1;
        drive(1, 1, 2, 0, 0, '0, 16'h1234, 0); tick();
        drive(1, 1, 2, 1, 0, '0, 16'h1234, 0); tick();
        checkOutput("const_reenter_running", 256'(running), 256'(1));
        drive(1, 1, 2, 0, 0, '0, 16'h1234, 0); tick();
        checkOutput("const_reenter_tdata", tx_tdata, constWord(16'h1234));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
